// File: rtl/ag_tcu_fedp_int_acc.sv
// ag_tcu_fedp_int_acc -- pipelined integer fused dot-product with K accumulation.
//
// Purpose: each accepted beat carries N lanes of packed i8/u8/i4/u4 operands.
// Per lane the products of one 32-bit word are summed, the lane sums are
// reduced by a registered adder tree, and the ACC stage chains beats between
// in_first and in_last into one result. Full valid/ready backpressure: when
// the output is held, every stage freezes.
//
// Optional feature: define AG_TCU_FEDP_SAT_EN to make the ACC stage saturate
// to the signed ACCW range; a sticky saturation flag then ORs into out_err.
// Without it the accumulator wraps modulo 2^ACCW.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_ready     beat handshake (in_ready = not stalled)
//   in_first/in_last      accumulation markers
//   fmt_s                 1=i8 2=u8 3=i4 4=u4, anything else illegal
//   a_row/b_col           N x XLEN packed operands (low 32 bits per lane used)
//   c_val                 accumulator seed on a first beat
//   out_valid/out_ready   result handshake
//   d_val                 result, NaN-boxed with ones above ACCW
//   out_err               illegal fmt (or saturation) in this accumulation
module ag_tcu_fedp_int_acc #(
  parameter int N       = 4,
  parameter int XLEN    = 32,
  parameter int ACCW    = 32,
  parameter int LATENCY = 3 + $clog2(N)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [2:0]          fmt_s,
  input  logic [N*XLEN-1:0]   a_row,
  input  logic [N*XLEN-1:0]   b_col,
  input  logic [XLEN-1:0]     c_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     d_val,
  output logic                out_err
);

  localparam int L     = $clog2(N);
  localparam int RW    = 19 + L;     // reduction width
  localparam int NS    = L + 2;      // M1, M2, L tree levels
  localparam int TOP   = NS - 1;     // sideband index aligned with tree root
  localparam int NODES = 2 * N - 1;

  if (LATENCY != 3 + L) begin : g_bad_latency
    $error("LATENCY must equal 3+$clog2(N)");
  end
  if (ACCW != 32 && ACCW != 64) begin : g_bad_accw
    $error("ACCW must be 32 or 64");
  end
  if (ACCW > XLEN) begin : g_bad_xlen
    $error("ACCW must not exceed XLEN");
  end

  logic out_valid_q;
  logic out_err_q;
  logic [ACCW-1:0] d_q;
  logic adv;

  // Only the output register can stall; everything upstream moves in lockstep.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  logic fmt_byte, fmt_sgn, fmt_ill;
  always_comb begin
    fmt_byte = 1'b0;
    fmt_sgn  = 1'b0;
    fmt_ill  = 1'b0;
    case (fmt_s)
      3'd1: begin fmt_byte = 1'b1; fmt_sgn = 1'b1; end
      3'd2: fmt_byte = 1'b1;
      3'd3: fmt_sgn = 1'b1;
      3'd4: ;
      default: fmt_ill = 1'b1;
    endcase
  end

  // Heap-ordered adder tree: leaves N-1..2N-2 are the per-lane M2 sums,
  // node i adds children 2i+1 and 2i+2, node 0 is the reduced beat sum.
  logic signed [RW-1:0] tree_w [NODES];

  genvar gi, gk;
  for (gi = 0; gi < N; gi++) begin : g_lane
    logic [31:0] a_w, b_w;
    logic signed [17:0] pb [4];
    logic signed [17:0] pn [8];
    logic signed [17:0] part0_d, part1_d, part0_q, part1_q;
    logic signed [RW-1:0] word_q;

    assign a_w = a_row[gi*XLEN +: 32];
    assign b_w = b_col[gi*XLEN +: 32];

    // Operands widened by one bit carrying sign (signed fmt) or zero.
    for (gk = 0; gk < 4; gk++) begin : g_byte
      logic signed [8:0] ax, bx;
      assign ax     = {fmt_sgn & a_w[8*gk+7], a_w[8*gk +: 8]};
      assign bx     = {fmt_sgn & b_w[8*gk+7], b_w[8*gk +: 8]};
      assign pb[gk] = 18'(ax) * 18'(bx);
    end
    for (gk = 0; gk < 8; gk++) begin : g_nib
      logic signed [4:0] ax, bx;
      assign ax     = {fmt_sgn & a_w[4*gk+3], a_w[4*gk +: 4]};
      assign bx     = {fmt_sgn & b_w[4*gk+3], b_w[4*gk +: 4]};
      assign pn[gk] = 18'(ax) * 18'(bx);
    end

    always_comb begin
      part0_d = '0;
      part1_d = '0;
      if (!fmt_ill) begin
        if (fmt_byte) begin
          part0_d = pb[0] + pb[1];
          part1_d = pb[2] + pb[3];
        end else begin
          part0_d = pn[0] + pn[1] + pn[2] + pn[3];
          part1_d = pn[4] + pn[5] + pn[6] + pn[7];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        part0_q <= part0_d;
        part1_q <= part1_d;
        word_q  <= {{(RW-18){part0_q[17]}}, part0_q} + {{(RW-18){part1_q[17]}}, part1_q};
      end
    end

    assign tree_w[N-1+gi] = word_q;
  end

  for (gi = 0; gi < N - 1; gi++) begin : g_node
    logic signed [RW-1:0] sum_q;
    always_ff @(posedge clk) begin
      if (adv) sum_q <= tree_w[2*gi+1] + tree_w[2*gi+2];
    end
    assign tree_w[gi] = sum_q;
  end

  // Beat sideband travels alongside the datapath.
  logic            sb_valid_q [NS];
  logic            sb_first_q [NS];
  logic            sb_last_q  [NS];
  logic            sb_ill_q   [NS];
  logic [ACCW-1:0] sb_c_q     [NS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < NS; s++) sb_valid_q[s] <= 1'b0;
    end else if (adv) begin
      sb_valid_q[0] <= in_valid;
      for (int s = 1; s < NS; s++) sb_valid_q[s] <= sb_valid_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sb_first_q[0] <= in_first;
      sb_last_q[0]  <= in_last;
      sb_ill_q[0]   <= fmt_ill;
      sb_c_q[0]     <= c_val[ACCW-1:0];
      for (int s = 1; s < NS; s++) begin
        sb_first_q[s] <= sb_first_q[s-1];
        sb_last_q[s]  <= sb_last_q[s-1];
        sb_ill_q[s]   <= sb_ill_q[s-1];
        sb_c_q[s]     <= sb_c_q[s-1];
      end
    end
  end

  // ACC stage: single-cycle feedback so consecutive beats need no bubble.
  logic [ACCW-1:0] acc_q, base, red_ext, acc_d;
  logic err_acc_q, err_d, sat, acc_fire;
`ifdef AG_TCU_FEDP_SAT_EN
  logic [ACCW:0] sum_w;
`endif

  assign acc_fire = adv && sb_valid_q[TOP];

  always_comb begin
    base    = sb_first_q[TOP] ? sb_c_q[TOP] : acc_q;
    red_ext = {{(ACCW-RW){tree_w[0][RW-1]}}, tree_w[0]};
`ifdef AG_TCU_FEDP_SAT_EN
    sum_w = {base[ACCW-1], base} + {red_ext[ACCW-1], red_ext};
    sat   = sum_w[ACCW] ^ sum_w[ACCW-1];
    if (sat) acc_d = sum_w[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    else     acc_d = sum_w[ACCW-1:0];
`else
    sat   = 1'b0;
    acc_d = base + red_ext;
`endif
    err_d = (sb_first_q[TOP] ? 1'b0 : err_acc_q) | sb_ill_q[TOP] | sat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      acc_q       <= '0;
      err_acc_q   <= 1'b0;
    end else if (adv) begin
      // Not stalled means the old result (if any) was taken this cycle.
      out_valid_q <= sb_valid_q[TOP] && sb_last_q[TOP];
      if (acc_fire) begin
        acc_q     <= acc_d;
        err_acc_q <= err_d;
      end
      if (acc_fire && sb_last_q[TOP]) out_err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_fire && sb_last_q[TOP]) d_q <= acc_d;
  end

  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

  if (XLEN > ACCW) begin : g_nanbox
    assign d_val = {{(XLEN-ACCW){1'b1}}, d_q};
  end else begin : g_plain
    assign d_val = d_q;
  end

endmodule

// File: doc/ag_tcu_fedp_int_acc.md
Name: ag_tcu_fedp_int_acc

Overview:
- Pipelined integer fused dot-product unit for the AG tensor core: N lanes of packed i8/u8/i4/u4 operands.
- Adds a valid/ready handshake with full backpressure.
- Adds multi-beat K accumulation: an internal accumulator chains beats between first/last markers, so one result covers K = beats × N × elements-per-word.
- Sits between the TCU operand collector and the writeback queue, and replaces the single-shot, enable-gated integer FEDP.

Parameters:
- N, 4, lanes per beat; power of two, ≥1.
- ACCW, 32, accumulator and result width; 32 or 64, ≤ XLEN when XLEN=64.
- LATENCY, 3+$clog2(N), in-to-out pipeline depth; static assert on mismatch.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_first  in  1  beat starts a new accumulation; base = c_val
- in_last  in  1  beat ends accumulation; produces one output
- fmt_s  in  3  1=i8, 2=u8, 3=i4, 4=u4, others illegal
- a_row  in  N×XLEN  packed A operands; low 32 bits of each lane used
- b_col  in  N×XLEN  packed B operands
- c_val  in  XLEN  accumulator seed; low ACCW bits used
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- d_val  out  XLEN  result; upper 32 bits all-ones when XLEN=64 and ACCW=32 (NaN-box)
- out_err  out  1  illegal fmt seen in any beat of this accumulation

Behaviour:
- Reset (reset_n=0 at posedge): all stage valid bits, out_valid, out_err, and the accumulator are cleared to 0. in_ready=1 in the cycle after reset. Reset mid-operation drops all in-flight beats and any partial accumulation.
- Pipeline advance: stall = out_valid && !out_ready. When stalled, every stage holds and in_ready=0. in_ready is combinational from the stall term and the output-stage valid only, never from in_valid.
- Stage M1: per-lane partial products, pairs of bytes (8-bit) or quads of nibbles (4-bit), signed or unsigned per fmt_s. fmt_s travels down the pipe with the beat.
- Stage M2: per-lane word sum, sign- or zero-extended to 19 bits.
- Reduction: $clog2(N) registered adder levels, width 19+$clog2(N), sign-extended.
- Stage ACC, single-cycle feedback:
  - acc_next = (first ? sext(c_val) : acc) + sext(red), modulo 2^ACCW.
  - The accumulator updates only on a valid beat. Back-to-back beats need no bubble.
  - On a valid beat with last=1: out_valid<=1, d_val<=acc_next. The accumulator keeps its value but is ignored until the next first.
- first&&last on the same beat = single-shot: d_val = c_val + dot.
- A beat with first=0 arriving after a last (no open accumulation) accumulates onto the stale value. Legal, undefined result.
- Illegal fmt: that beat contributes 0 to the sum; out_err=1 on the output of its accumulation. out_err is cleared by the next first.
- Output holds d_val/out_err stable while out_valid&&!out_ready. Output clears on handshake unless a new last beat lands in the same cycle.
- Throughput: 1 beat/cycle when out_ready=1.
- Empty pipe: out_valid stays 0. An accumulation never terminated by last never produces output.

Optional Feature:
- Macro: AG_TCU_FEDP_SAT_EN.
- Defined:
  - The ACC stage adds with saturation to signed ACCW range: 0x7FFFFFFF / 0x80000000 for ACCW=32.
  - A sticky saturation flag ORs into out_err for that accumulation.
- Undefined: wrap-around modulo 2^ACCW; out_err reflects illegal fmt only.

Test Plan:
- Single-shot, N=4, fmt=1 (i8): all a bytes=0x02, all b bytes=0xFD (-3), c=10, first=last=1 -> d_val=10+16×(-6)=-86 (0xFFFFFFAA), out_valid exactly LATENCY=5 cycles after accept.
- u4, N=4: all nibbles a=0xF, b=0xF, c=0 -> d_val=32×225=7200. Same operands with fmt=3 (i4) -> 32×1=32.
- 3-beat accumulation, back-to-back, fmt=2, each beat dot=1000, c=5 -> exactly one output, d_val=3005. No output for the first two beats.
- Backpressure: out_ready=0 for 6 cycles while 8 single-shot beats are offered -> in_ready drops, no beat lost or duplicated, d_val stable while stalled, all 8 results delivered in order.
- fmt=7 in the middle beat of 3 -> d_val = sum of the other two beats + c, out_err=1. The next accumulation has out_err=0.
- Reset (reset_n=0 for one cycle) mid-accumulation with 3 beats in flight -> out_valid=0 next cycle, no stale output. A new first=last beat gives a correct result. With AG_TCU_FEDP_SAT_EN: c=0x7FFFFF00 plus a dot of +1000 -> d_val=0x7FFFFFFF, out_err=1.
